accl_pair_feeder: RTL and testbench
===================================

Name: accl_pair_feeder

Overview:
- Drives the pipelined gravitational-acceleration unit, getAccl: x1, y1, x2, y2, m2 in, ax, ay out, fixed 122-cycle latency, no handshake.
- Walks every ordered body pair (i target, j source, j≠i) from a dual-read body memory. Issues at most one pair per cycle.
- Carries a tag through a delay line matched to the unit's latency, so the downstream accumulator knows which ax/ay are valid and which body they belong to.

Parameters:
- IDX_W, 8, body index width; max bodies 2^IDX_W.
- DATA_W, 64, IEEE-754 double width.
- LATENCY, 122, getAccl input-to-output latency in cycles.
- RD_LAT, 1, body-memory read latency in cycles; fixed at 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- n_bodies  in  IDX_W  body count; latched on start.
- hold  in  1  suppress issue this cycle (inserts a bubble).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- rd_addr_i  out  IDX_W  target read address.
- rd_addr_j  out  IDX_W  source read address.
- rd_x_i, rd_y_i  in  DATA_W  target data, RD_LAT after address.
- rd_x_j, rd_y_j, rd_m_j  in  DATA_W  source data.
- x1, y1, x2, y2, m2  out  DATA_W  registered getAccl inputs.
- acc_valid  out  1  ax/ay at getAccl output this cycle are a real pair.
- acc_idx  out  IDX_W  target index i of that result.
- acc_first, acc_last  out  1  first / last source for that target.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; busy, done, acc_valid, acc_first, acc_last = 0; acc_idx, rd_addr_i, rd_addr_j = 0; x1, y1, x2, y2, m2 = 0; whole tag delay line cleared.
- Reset mid-sweep: in-flight tags are discarded; no acc_valid after reset.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 at cycle S.
  - If n_bodies<2, go to FIN. No pairs issued, busy never rises.
  - Otherwise load i=0, j=1 and go to ISSUE.
- ISSUE, one cycle per issue slot:
  - If hold=0: issue (i,j). Drive rd_addr_i=i, rd_addr_j=j. Push tag {valid=1, i, first=(j is first non-i source), last=(j is last non-i source)}.
  - Advance j to the next index ≠i.
  - On wrap past n_bodies-1: i increments and j restarts at 0, or at 1 when the new i=0.
  - If hold=1: addresses unchanged, push tag valid=0.
  - After pair (n-1, n-2) issues, go to DRAIN.
- Self-pairs (j==i) are never issued; zero separation gives NaN in getAccl.
- Data path:
  - Read data arrives RD_LAT=1 after the address.
  - x1, y1 ← rd_x_i, rd_y_i and x2, y2, m2 ← rd_x_j, rd_y_j, rd_m_j are registered on the next edge, 2 cycles after the address.
  - These registers load every cycle, including bubbles.
- Tag delay line:
  - Depth LATENCY+2 shift register.
  - The tag pushed at address cycle t appears on acc_* at cycle t+2+LATENCY, aligned with getAccl ax/ay.
  - acc_idx, acc_first, acc_last are don't-care when acc_valid=0.
- DRAIN: counter runs LATENCY+2 cycles after the last issue, then go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy = 1 in ISSUE and DRAIN only.
- start while busy is ignored.
- hold in DRAIN or IDLE has no effect.
- n_bodies changes after start are ignored (value latched).
- Pair count per sweep: n·(n−1). Index arithmetic is IDX_W-bit unsigned.

Optional Feature:
- Macro ACCL_FEEDER_PERF_EN.
- Defined: adds outputs perf_cycles [31:0] (cycles busy=1) and perf_bubbles [31:0] (hold-induced bubbles).
  - Both clear on start and hold their value after done until the next start.
  - Both reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- n=3, start at S, hold=0 throughout:
  - issue order (0,1),(0,2),(1,0),(1,2),(2,0),(2,1) at S+1..S+6;
  - acc_valid high S+125..S+130, acc_idx 0,0,1,1,2,2;
  - acc_first on 1st/3rd/5th, acc_last on 2nd/4th/6th;
  - done at S+131; busy high S+1..S+130.
- n=3 with hold=1 at S+2 only: one bubble; acc_valid low at S+126; six valid results end at S+131; done at S+132.
  - With ACCL_FEEDER_PERF_EN: perf_bubbles=1, perf_cycles=131.
- Data alignment: body 0=(10,20,m500), body 1=(0,0,m400). Check x1=10, y1=20, x2=0, y2=0, m2=400 at S+3; tag for pair (0,1) exits at S+125.
- n=1 and n=0: done at S+1, busy and acc_valid never assert.
- Reset (rst=0) at S+50 of an n=4 sweep: all outputs 0 next cycle; no acc_valid thereafter. A new start runs a full 12-pair sweep correctly.
- start pulsed while busy: ignored; a single done; pair count unchanged.

Source files
------------

// File: rtl/accl_pair_feeder.sv
// rtl/accl_pair_feeder.sv - ordered body-pair issuer and tag pipeline for the getAccl unit
//
// Purpose:
//   Walks every ordered body pair (i target, j source, j != i) of an
//   n-body set held in a dual-read body memory and feeds the pipelined
//   getAccl unit one pair per cycle. A tag {valid, i, first, last} travels
//   through a shift register whose depth matches the address-to-result path,
//   so acc_* line up with the ax/ay leaving getAccl.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, n_bodies          begin a sweep over n_bodies bodies (IDLE only)
//   hold                     bubble request for the current issue slot
//   busy, done               sweep in progress / one-cycle completion pulse
//   rd_addr_i, rd_addr_j     target / source body-memory read addresses
//   rd_x_i, rd_y_i           target body data (RD_LAT after address)
//   rd_x_j, rd_y_j, rd_m_j   source body data (RD_LAT after address)
//   x1, y1, x2, y2, m2       registered getAccl operands
//   acc_valid, acc_idx       result-valid and target index at getAccl output
//   acc_first, acc_last      first / last source for that target
//   perf_cycles, perf_bubbles  busy-cycle and bubble counters
//                            (only when ACCL_FEEDER_PERF_EN is defined)
//
// Build option: ACCL_FEEDER_PERF_EN adds the performance counters.

module accl_pair_feeder #(
  parameter int IDX_W   = 8,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 122,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_bodies,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rd_addr_i,
  output logic [IDX_W-1:0]  rd_addr_j,
  input  logic [DATA_W-1:0] rd_x_i,
  input  logic [DATA_W-1:0] rd_y_i,
  input  logic [DATA_W-1:0] rd_x_j,
  input  logic [DATA_W-1:0] rd_y_j,
  input  logic [DATA_W-1:0] rd_m_j,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] m2,
  output logic              acc_valid,
  output logic [IDX_W-1:0]  acc_idx,
  output logic              acc_first,
  output logic              acc_last
`ifdef ACCL_FEEDER_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_bubbles
`endif
);

  // Address cycle -> read data (RD_LAT) -> operand register (1) -> getAccl.
  // The tag line covers everything before getAccl plus its latency.
  localparam int TAG_DEPTH = LATENCY + RD_LAT + 1;
  localparam int CNT_W     = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   n_q;
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   j_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   drain_cnt_q;

  // Pair-walk helpers for the current (i, j).
  logic [IDX_W-1:0]   first_src_d;
  logic [IDX_W-1:0]   last_src_d;
  logic               is_first_d;
  logic               is_last_d;
  logic [IDX_W-1:0]   j_inc_d;
  logic [IDX_W-1:0]   j_next_d;
  logic [IDX_W-1:0]   i_inc_d;
  logic               sweep_end_d;
  logic               push_d;

  always_comb begin
    first_src_d = (i_q == '0) ? IDX_W'(1) : '0;
    // Target n-1 has n-2 as its last source; all others end at n-1.
    last_src_d  = (i_q == n_q - IDX_W'(1)) ? (n_q - IDX_W'(2)) : (n_q - IDX_W'(1));
    is_first_d  = (j_q == first_src_d);
    is_last_d   = (j_q == last_src_d);
    j_inc_d     = j_q + IDX_W'(1);
    // Skip the self-pair: getAccl would divide by a zero separation.
    j_next_d    = (j_inc_d == i_q) ? (j_q + IDX_W'(2)) : j_inc_d;
    i_inc_d     = i_q + IDX_W'(1);
    sweep_end_d = is_last_d && (i_q == n_q - IDX_W'(1));
    push_d      = (state_q == ISSUE) && !hold;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            n_q <= n_bodies;
            if (n_bodies < IDX_W'(2)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              i_q     <= '0;
              j_q     <= IDX_W'(1);
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A held slot leaves (i, j) in place so the same pair retries.
          if (!hold) begin
            if (sweep_end_d) begin
              drain_cnt_q <= '0;
              state_q     <= DRAIN;
            end else if (is_last_d) begin
              i_q <= i_inc_d;
              j_q <= (i_inc_d == '0) ? IDX_W'(1) : '0;
            end else begin
              j_q <= j_next_d;
            end
          end
        end
        DRAIN: begin
          // Wait until the last pushed tag has left the tag line.
          if (drain_cnt_q == CNT_W'(TAG_DEPTH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr_i = i_q;
  assign rd_addr_j = j_q;

  // Operand registers load every cycle; bubbles carry whatever was read and
  // are marked invalid by the tag line.
  logic [DATA_W-1:0] x1_q, y1_q, x2_q, y2_q, m2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x1_q <= '0;
      y1_q <= '0;
      x2_q <= '0;
      y2_q <= '0;
      m2_q <= '0;
    end else begin
      x1_q <= rd_x_i;
      y1_q <= rd_y_i;
      x2_q <= rd_x_j;
      y2_q <= rd_y_j;
      m2_q <= rd_m_j;
    end
  end

  assign x1 = x1_q;
  assign y1 = y1_q;
  assign x2 = x2_q;
  assign y2 = y2_q;
  assign m2 = m2_q;

  // Tag delay line. A tag pushed while its address is on rd_addr_* reaches
  // the last stage exactly when getAccl presents that pair's ax/ay.
  logic [TAG_DEPTH-1:0] tag_valid_q;
  logic [TAG_DEPTH-1:0] tag_first_q;
  logic [TAG_DEPTH-1:0] tag_last_q;
  logic [IDX_W-1:0]     tag_idx_q [TAG_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_valid_q <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      tag_valid_q  <= {tag_valid_q[TAG_DEPTH-2:0], push_d};
      tag_first_q  <= {tag_first_q[TAG_DEPTH-2:0], push_d && is_first_d};
      tag_last_q   <= {tag_last_q[TAG_DEPTH-2:0], push_d && is_last_d};
      tag_idx_q[0] <= i_q;
      for (int k = 1; k < TAG_DEPTH; k++) begin
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  assign acc_valid = tag_valid_q[TAG_DEPTH-1];
  assign acc_first = tag_first_q[TAG_DEPTH-1];
  assign acc_last  = tag_last_q[TAG_DEPTH-1];
  assign acc_idx   = tag_idx_q[TAG_DEPTH-1];

`ifdef ACCL_FEEDER_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_bubbles_q;

  // Cleared by an accepted start; otherwise they keep the last sweep's totals.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q  <= '0;
      perf_bubbles_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles_q  <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (busy_q) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (state_q == ISSUE && hold) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_accl_pair_feeder.sv
// tb/tb_accl_pair_feeder.sv - table-driven self-checking bench for accl_pair_feeder

module tb_accl_pair_feeder;

  localparam int IDX_W  = 8;
  localparam int DATA_W = 64;
  localparam int LAT    = 122;
  localparam int PIPE   = LAT + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  n_bodies = '0;
  logic              hold = 1'b0;
  logic              busy, done;
  logic [IDX_W-1:0]  rd_addr_i, rd_addr_j;
  logic [DATA_W-1:0] rd_x_i, rd_y_i, rd_x_j, rd_y_j, rd_m_j;
  logic [DATA_W-1:0] x1, y1, x2, y2, m2;
  logic              acc_valid, acc_first, acc_last;
  logic [IDX_W-1:0]  acc_idx;
`ifdef ACCL_FEEDER_PERF_EN
  logic [31:0]       perf_cycles, perf_bubbles;
`endif

  always #5 clk = ~clk;

  accl_pair_feeder #(.IDX_W(IDX_W), .DATA_W(DATA_W), .LATENCY(LAT), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies), .hold(hold),
    .busy(busy), .done(done), .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
    .rd_x_i(rd_x_i), .rd_y_i(rd_y_i), .rd_x_j(rd_x_j), .rd_y_j(rd_y_j), .rd_m_j(rd_m_j),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .acc_valid(acc_valid), .acc_idx(acc_idx), .acc_first(acc_first), .acc_last(acc_last)
`ifdef ACCL_FEEDER_PERF_EN
    , .perf_cycles(perf_cycles), .perf_bubbles(perf_bubbles)
`endif
  );

  // Body memory: one-cycle read latency on both ports.
  logic [DATA_W-1:0] mem_x [256];
  logic [DATA_W-1:0] mem_y [256];
  logic [DATA_W-1:0] mem_m [256];

  always @(posedge clk) begin
    rd_x_i <= mem_x[rd_addr_i];
    rd_y_i <= mem_y[rd_addr_i];
    rd_x_j <= mem_x[rd_addr_j];
    rd_y_j <= mem_y[rd_addr_j];
    rd_m_j <= mem_m[rd_addr_j];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int n;
    int hold_off;     // cycle offset with hold=1, -1 for none
    int restart_off;  // offset of an extra start pulse, -1 for none
    int exp_pairs;
    int exp_bubbles;
    int exp_done;     // offset of the done pulse
  } vec_t;

  vec_t tbl[8];

  // Offset 0 is the cycle in which start is driven; offset k is observed
  // at the k-th following falling edge.
  task automatic run_sweep(input vec_t v);
    int pi[400], pj[400], pf[400], pl[400];
    int addr_at[300], issued_at[300];
    int np, p, cnt, n_valid, n_done, limit;
    logic exp_valid, exp_busy;
    np = 0;
    for (int i = 0; i < v.n; i++) begin
      cnt = 0;
      for (int j = 0; j < v.n; j++) begin
        if (j != i) begin
          pi[np] = i; pj[np] = j;
          pf[np] = (cnt == 0) ? 1 : 0;
          pl[np] = (cnt == v.n - 2) ? 1 : 0;
          cnt++; np++;
        end
      end
    end
    for (int k = 0; k < 300; k++) begin
      addr_at[k] = -1; issued_at[k] = -1;
    end
    p = 0;
    for (int k = 1; p < np; k++) begin
      addr_at[k] = p;
      if (k != v.hold_off) begin
        issued_at[k] = p;
        p++;
      end
    end
    limit = v.exp_done + 4;
    n_valid = 0;
    n_done = 0;
    for (int k = 0; k <= limit; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (addr_at[k] >= 0) begin
          chk("rd_addr_i", 64'(rd_addr_i), 64'(pi[addr_at[k]]));
          chk("rd_addr_j", 64'(rd_addr_j), 64'(pj[addr_at[k]]));
        end
        if (k >= 3 && addr_at[k-2] >= 0) begin
          chk("x1", x1, mem_x[pi[addr_at[k-2]]]);
          chk("y1", y1, mem_y[pi[addr_at[k-2]]]);
          chk("x2", x2, mem_x[pj[addr_at[k-2]]]);
          chk("y2", y2, mem_y[pj[addr_at[k-2]]]);
          chk("m2", m2, mem_m[pj[addr_at[k-2]]]);
        end
        exp_valid = (k - PIPE >= 1) && (issued_at[k-PIPE] >= 0);
        chk("acc_valid", 64'(acc_valid), 64'(exp_valid));
        if (exp_valid) begin
          chk("acc_idx", 64'(acc_idx), 64'(pi[issued_at[k-PIPE]]));
          chk("acc_first", 64'(acc_first), 64'(pf[issued_at[k-PIPE]]));
          chk("acc_last", 64'(acc_last), 64'(pl[issued_at[k-PIPE]]));
        end
        exp_busy = (v.n >= 2) && (k < v.exp_done);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(k == v.exp_done));
        if (acc_valid) n_valid++;
        if (done) n_done++;
      end
      start    = (k == 0) || (k == v.restart_off);
      n_bodies = (k == 0) ? IDX_W'(v.n) : IDX_W'(9);
      hold     = (k == v.hold_off);
    end
    start = 1'b0;
    hold  = 1'b0;
    chk("pair_results", 64'(n_valid), 64'(v.exp_pairs));
    chk("done_pulses", 64'(n_done), 64'd1);
`ifdef ACCL_FEEDER_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'((v.n >= 2) ? v.exp_done - 1 : 0));
    chk("perf_bubbles", 64'(perf_bubbles), 64'(v.exp_bubbles));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
    chk({tag, "_acc_idx"}, 64'(acc_idx), 64'd0);
    chk({tag, "_acc_first"}, 64'(acc_first), 64'd0);
    chk({tag, "_acc_last"}, 64'(acc_last), 64'd0);
    chk({tag, "_rd_addr_i"}, 64'(rd_addr_i), 64'd0);
    chk({tag, "_rd_addr_j"}, 64'(rd_addr_j), 64'd0);
    chk({tag, "_x1"}, x1, 64'd0);
    chk({tag, "_y1"}, y1, 64'd0);
    chk({tag, "_x2"}, x2, 64'd0);
    chk({tag, "_y2"}, y2, 64'd0);
    chk({tag, "_m2"}, m2, 64'd0);
  endtask

  int stray;

  initial begin
    for (int b = 0; b < 256; b++) begin
      mem_x[b] = $realtobits(real'(b) * 1.5);
      mem_y[b] = $realtobits(real'(b) * 2.5 + 1.0);
      mem_m[b] = $realtobits(100.0 + real'(b));
    end
    mem_x[0] = $realtobits(10.0); mem_y[0] = $realtobits(20.0); mem_m[0] = $realtobits(500.0);
    mem_x[1] = $realtobits(0.0);  mem_y[1] = $realtobits(0.0);  mem_m[1] = $realtobits(400.0);

    //          n  hold restart pairs bubbles done
    tbl[0] = '{3, -1, -1,  6, 0, 131};
    tbl[1] = '{3,  2, -1,  6, 1, 132};
    tbl[2] = '{1, -1, -1,  0, 0,   1};
    tbl[3] = '{0,  5, -1,  0, 0,   1};
    tbl[4] = '{4, -1, 20, 12, 0, 137};
    tbl[5] = '{2,  1, -1,  2, 1, 128};
    tbl[6] = '{2, 10, -1,  2, 0, 127};
    tbl[7] = '{5,  3, -1, 20, 1, 146};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
`ifdef ACCL_FEEDER_PERF_EN
    chk("reset_perf_cycles", 64'(perf_cycles), 64'd0);
    chk("reset_perf_bubbles", 64'(perf_bubbles), 64'd0);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Hand-checked data alignment for the first n=3 sweep: operands of
    // pair (0,1) two cycles after issue.
    start = 1'b1; n_bodies = 8'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("align_x1", x1, $realtobits(10.0));
    chk("align_y1", y1, $realtobits(20.0));
    chk("align_x2", x2, $realtobits(0.0));
    chk("align_y2", y2, $realtobits(0.0));
    chk("align_m2", m2, $realtobits(400.0));
    repeat (140) @(negedge clk);
    chk("align_idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 8; v++) begin
      run_sweep(tbl[v]);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of an n=4 sweep (during drain, tags in flight).
    start = 1'b1; n_bodies = 8'd4;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b1;
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_valid || busy || done) stray++;
    end
    chk("midrst_no_activity", 64'(stray), 64'd0);

    run_sweep(tbl[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
